// File: rtl/capture_pkg.sv
// capture_pkg: shared state encoding for the capture sequencer.
package capture_pkg;
    localparam int STATE_W = 3;
    typedef enum logic [STATE_W-1:0] {
        IDLE  = 3'd0,
        PRE   = 3'd1,
        ARMED = 3'd2,
        POST  = 3'd3,
        DONE  = 3'd4
    } state_e;
endpackage

// File: rtl/cap_timeout_cnt.sv
// cap_timeout_cnt: clearable clock counter that pulses expire_o on the cycle the count reaches a nonzero limit.
module cap_timeout_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] limit_i,
    output logic         expire_o
);
    logic [W-1:0] cnt_q;
    // the enabled cycle that would make the count equal the limit is the expiry cycle
    assign expire_o = en_i && (limit_i != '0) && (cnt_q + W'(1) == limit_i);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else if (clr_i) cnt_q <= '0;
        else if (en_i) cnt_q <= cnt_q + W'(1);
    end
endmodule

// File: rtl/capture_ctrl.sv
// capture_ctrl: arms the matcher, fills the circular capture RAM around a trigger
// (or timeout) and reports the frozen buffer window.
module capture_ctrl
    import capture_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int TRIG_LAT   = 2,
    parameter int TO_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_start,
    input  logic                  cfg_abort,
    input  logic [ADDR_WIDTH-1:0] cfg_pre_depth,
    input  logic [ADDR_WIDTH-1:0] cfg_post_depth,
    input  logic [TO_WIDTH-1:0]   cfg_timeout,
    input  logic [DATA_WIDTH-1:0] cap_data,
    input  logic                  cap_data_vld,
    input  logic                  tri_succeed,
    output logic                  trigger_enable,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic [ADDR_WIDTH-1:0] trig_addr,
    output logic [ADDR_WIDTH-1:0] rd_base,
    output logic                  busy,
    output logic                  done,
    output logic                  timed_out,
    output logic                  aborted
);
    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d, pre_cnt_q, pre_cnt_d, post_cnt_q, post_cnt_d;
    logic [ADDR_WIDTH-1:0]   trig_addr_q, trig_addr_d, rd_base_q, rd_base_d, trig_new;
    logic                    timed_out_q, timed_out_d, aborted_q, aborted_d;
    logic                    te_q, wr_en_q, expire, wr;
    logic [ADDR_WIDTH-1:0]   wr_addr_q;
    logic [DATA_WIDTH-1:0]   wr_data_q;

    cap_timeout_cnt #(.W(TO_WIDTH)) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (state_q != ARMED),
        .en_i     (state_q == ARMED),
        .limit_i  (cfg_timeout),
        .expire_o (expire)
    );

    assign busy     = (state_q == PRE) || (state_q == ARMED) || (state_q == POST);
    assign done     = state_q == DONE;
    assign wr       = busy && cap_data_vld;
    // the matcher reports TRIG_LAT samples after the triggering one entered
    assign trig_new = ptr_q - ADDR_WIDTH'(TRIG_LAT);

    always_comb begin
        state_d     = state_q;
        ptr_d       = wr ? ptr_q + ADDR_WIDTH'(1) : ptr_q;
        pre_cnt_d   = pre_cnt_q;
        post_cnt_d  = post_cnt_q;
        trig_addr_d = trig_addr_q;
        rd_base_d   = rd_base_q;
        timed_out_d = timed_out_q;
        aborted_d   = aborted_q;
        if (cfg_abort) begin
            state_d     = IDLE;
            aborted_d   = aborted_q || busy;
            timed_out_d = 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: if (cfg_start) begin
                    state_d     = (cfg_pre_depth != '0) ? PRE : ARMED;
                    ptr_d       = '0;
                    pre_cnt_d   = '0;
                    post_cnt_d  = '0;
                    timed_out_d = 1'b0;
                    aborted_d   = 1'b0;
                end
                PRE: if (wr) begin
                    pre_cnt_d = pre_cnt_q + ADDR_WIDTH'(1);
                    state_d   = (pre_cnt_d == cfg_pre_depth) ? ARMED : PRE;
                end
                ARMED: if (tri_succeed) begin
                    trig_addr_d = trig_new;
                    rd_base_d   = trig_new - cfg_pre_depth;
                    state_d     = (cfg_post_depth != '0) ? POST : DONE;
                end else if (expire) begin
                    trig_addr_d = ptr_q;
                    rd_base_d   = ptr_q - cfg_pre_depth;
                    state_d     = DONE;
                    timed_out_d = 1'b1;
                end
                POST: if (wr) begin
                    post_cnt_d = post_cnt_q + ADDR_WIDTH'(1);
                    state_d    = (post_cnt_d == cfg_post_depth) ? DONE : POST;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            pre_cnt_q   <= '0;
            post_cnt_q  <= '0;
            trig_addr_q <= '0;
            rd_base_q   <= '0;
            timed_out_q <= 1'b0;
            aborted_q   <= 1'b0;
            te_q        <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            pre_cnt_q   <= pre_cnt_d;
            post_cnt_q  <= post_cnt_d;
            trig_addr_q <= trig_addr_d;
            rd_base_q   <= rd_base_d;
            timed_out_q <= timed_out_d;
            aborted_q   <= aborted_d;
            te_q        <= state_q == ARMED;
            wr_en_q     <= wr && !cfg_abort;
            wr_addr_q   <= ptr_q;
            wr_data_q   <= cap_data;
        end
    end

    assign trigger_enable = te_q;
    assign wr_en          = wr_en_q;
    assign wr_addr        = wr_addr_q;
    assign wr_data        = wr_data_q;
    assign trig_addr      = trig_addr_q;
    assign rd_base        = rd_base_q;
    assign timed_out      = timed_out_q;
    assign aborted        = aborted_q;
endmodule

// File: tb/tb_capture_ctrl.sv
// tb_capture_ctrl: randomized capture runs checked against a log-based model of the capture window.
module tb_capture_ctrl;
    localparam int AW = 4;
    localparam int DW = 32;
    localparam int N  = 256;

    logic          clk = 1'b0, rst = 1'b1;
    logic          cfg_start = 1'b0, cfg_abort = 1'b0, cap_data_vld = 1'b0, tri_succeed = 1'b0;
    logic [AW-1:0] cfg_pre_depth = '0, cfg_post_depth = '0;
    logic [31:0]   cfg_timeout = '0;
    logic [DW-1:0] cap_data = '0;
    logic          trigger_enable, wr_en, busy, done, timed_out, aborted;
    logic [AW-1:0] wr_addr, trig_addr, rd_base;
    logic [DW-1:0] wr_data;

    capture_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TRIG_LAT(2), .TO_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
        .cfg_pre_depth(cfg_pre_depth), .cfg_post_depth(cfg_post_depth), .cfg_timeout(cfg_timeout),
        .cap_data(cap_data), .cap_data_vld(cap_data_vld), .tri_succeed(tri_succeed),
        .trigger_enable(trigger_enable), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .trig_addr(trig_addr), .rd_base(rd_base), .busy(busy), .done(done),
        .timed_out(timed_out), .aborted(aborted)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0;
    logic          vld_l [N];
    logic [DW-1:0] dat_l [N];
    logic          tri_l [N];

    // Cycle 0 carries the start pulse; samples from cycle 1 onward fill the buffer in order.
    task automatic run_capture(input string name, input int pre, input int post, input int to,
                               input int d, input int vp, input bit sp);
        int a, e, fin, ptr_e, cnt, k;
        bit trig, ew, et, ed, eb;
        logic [AW-1:0] exp_ta, exp_rb;
        cfg_pre_depth = AW'(pre); cfg_post_depth = AW'(post); cfg_timeout = 32'(to);
        for (int c = 0; c < N; c++) begin
            vld_l[c] = ($urandom_range(99) < vp);
            dat_l[c] = $urandom;
            tri_l[c] = 1'b0;
        end
        a = 0;
        if (pre > 0) begin
            a = N; cnt = 0;
            for (int c = 1; c < N; c++) if (vld_l[c]) begin
                cnt++;
                if (cnt == pre) begin a = c; break; end
            end
        end
        if (sp) for (int c = 0; c <= a && c < N; c++) tri_l[c] = ($urandom_range(3) == 0);
        if (d > 0 && a + d < N) tri_l[a + d] = 1'b1;
        e = N; trig = 0;
        for (int c = a + 1; c < N; c++) begin
            if (tri_l[c]) begin e = c; trig = 1; break; end
            if (to != 0 && c == a + to) begin e = c; break; end
        end
        ptr_e = 0;
        for (int c = 1; c < e && c < N; c++) ptr_e += int'(vld_l[c]);
        fin = e;
        if (trig && post > 0) begin
            fin = N; cnt = 0;
            for (int c = e + 1; c < N; c++) if (vld_l[c]) begin
                cnt++;
                if (cnt == post) begin fin = c; break; end
            end
        end
        if (sp && fin + 3 < N) tri_l[fin + 3] = 1'b1;
        exp_ta = AW'(ptr_e - (trig ? 2 : 0));
        exp_rb = exp_ta - AW'(pre);
        k = 0;
        for (int c = 0; c < N; c++) begin
            @(negedge clk);
            if (c > 0) begin
                ew = vld_l[c-1] && (c - 1 >= 1) && (c - 1 <= fin);
                et = (c >= a + 2) && (c <= e + 1);
                ed = c >= fin + 1;
                eb = c <= fin;
                n_cmp++;
                if (wr_en !== ew) begin
                    n_err++;
                    $display("FAIL %s wr_en cycle %0d: got %b want %b", name, c, wr_en, ew);
                end
                if (ew) begin
                    n_cmp++;
                    if ({wr_addr, wr_data} !== {AW'(k), dat_l[c-1]}) begin
                        n_err++;
                        $display("FAIL %s write cycle %0d: got addr %0d data %h want addr %0d data %h",
                                 name, c, wr_addr, wr_data, AW'(k), dat_l[c-1]);
                    end
                    k++;
                end
                n_cmp++;
                if ({trigger_enable, done, busy} !== {et, ed, eb}) begin
                    n_err++;
                    $display("FAIL %s te/done/busy cycle %0d: got %b%b%b want %b%b%b",
                             name, c, trigger_enable, done, busy, et, ed, eb);
                end
            end
            cfg_start = (c == 0); cap_data_vld = vld_l[c]; cap_data = dat_l[c]; tri_succeed = tri_l[c];
        end
        @(negedge clk);
        cap_data_vld = 1'b0; tri_succeed = 1'b0;
        n_cmp++;
        if ({trig_addr, rd_base, timed_out, aborted} !== {exp_ta, exp_rb, !trig, 1'b0}) begin
            n_err++;
            $display("FAIL %s window: got trig %0d base %0d to %b ab %b want trig %0d base %0d to %b ab 0",
                     name, trig_addr, rd_base, timed_out, aborted, exp_ta, exp_rb, !trig);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({trigger_enable, wr_en, wr_addr, wr_data, trig_addr, rd_base, busy, done, timed_out, aborted} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got nonzero outputs, want all 0");
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({busy, done, wr_en, trigger_enable} !== 4'b0) begin
            n_err++;
            $display("FAIL reset_release: got busy/done/wr_en/te %b%b%b%b want 0000", busy, done, wr_en, trigger_enable);
        end
    endtask

    task automatic test_basic();
        run_capture("basic", 4, 4, 0, 10, 100, 0);
    endtask

    task automatic test_zero_depth();
        run_capture("zero_depth", 0, 0, 0, 1, 100, 1);
    endtask

    task automatic test_wrap();
        run_capture("wrap", 12, 8, 0, 5, 100, 0);
        run_capture("wrap_rand", 12, 8, 0, int'($urandom_range(20, 1)), 70, 1);
    endtask

    task automatic test_timeout();
        run_capture("timeout", 4, 4, 20, 0, 80, 1);
        run_capture("timeout_tie", 4, 4, 20, 20, 80, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            int to, d;
            to = ($urandom_range(1) == 1) ? int'($urandom_range(40, 5)) : 0;
            d  = (to != 0 && $urandom_range(2) == 0) ? 0 : int'($urandom_range(40, 1));
            run_capture("random", int'($urandom_range(15)), int'($urandom_range(15)), to, d,
                        int'($urandom_range(100, 70)), 1);
        end
    endtask

    task automatic test_abort();
        cfg_pre_depth = 4; cfg_post_depth = 8; cfg_timeout = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c == 9) begin
                n_cmp++;
                if (busy !== 1'b1) begin n_err++; $display("FAIL abort_in_post: got busy %b want 1", busy); end
            end
            if (c == 10) begin
                n_cmp++;
                if ({busy, done, aborted} !== 3'b001) begin
                    n_err++;
                    $display("FAIL abort_state: got busy/done/aborted %b%b%b want 001", busy, done, aborted);
                end
            end
            if (c >= 11) begin
                n_cmp++;
                if (wr_en !== 1'b0) begin n_err++; $display("FAIL abort_no_write cycle %0d: got %b want 0", c, wr_en); end
            end
            cfg_start = (c == 0) || (c == 9); cfg_abort = (c == 9);
            cap_data_vld = 1'b1; cap_data = $urandom; tri_succeed = (c == 6);
        end
        @(negedge clk);
        cfg_start = 1'b1; cfg_abort = 1'b0; cap_data_vld = 1'b0;
        @(negedge clk);
        cfg_start = 1'b0;
        n_cmp++;
        if ({aborted, busy} !== 2'b01) begin
            n_err++;
            $display("FAIL abort_restart: got aborted/busy %b%b want 01", aborted, busy);
        end
        cfg_abort = 1'b1;
        @(negedge clk);
        cfg_abort = 1'b0;
    endtask

    task automatic test_rst_mid();
        int w;
        cfg_pre_depth = 4; cfg_post_depth = 4; cfg_timeout = 0;
        @(negedge clk);
        cfg_start = 1'b1; cap_data_vld = 1'b1; tri_succeed = 1'b0;
        @(negedge clk);
        cfg_start = 1'b0;
        w = 0;
        while (trigger_enable !== 1'b1 && w < 20) begin @(negedge clk); w++; end
        n_cmp++;
        if (trigger_enable !== 1'b1) begin n_err++; $display("FAIL rst_reach_armed: got te %b want 1", trigger_enable); end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({trigger_enable, wr_en, wr_addr, wr_data, trig_addr, rd_base, busy, done, timed_out, aborted} !== '0) begin
            n_err++;
            $display("FAIL rst_async_outputs: got nonzero outputs, want all 0");
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({wr_en, busy} !== 2'b00) begin n_err++; $display("FAIL rst_no_write: got wr_en/busy %b%b want 00", wr_en, busy); end
        @(negedge clk);
        rst = 1'b0; cap_data_vld = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_depth();
        test_wrap();
        test_timeout();
        test_random();
        test_abort();
        test_rst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
